// File: rtl/fuzz_stim_sequencer_if.sv
// Control/status and DUT-facing bus of the fuzz stimulus sequencer.
// The sequencer takes the slave modport; whoever drives runs takes master.
interface fuzz_stim_sequencer_if #(
  parameter int unsigned IN_W  = 139,
  parameter int unsigned OUT_W = 159
);
  logic             start;
  logic             abort;
  logic [31:0]      seed;
  logic [31:0]      num_cycles;
  logic [OUT_W-1:0] out_flat_i;
  logic [IN_W-1:0]  in_flat_o;
  logic             vec_valid;
  logic             busy;
  logic             done;
  logic [31:0]      vec_count;
  logic [31:0]      signature;

  modport master (
    output start, abort, seed, num_cycles, out_flat_i,
    input  in_flat_o, vec_valid, busy, done, vec_count, signature
  );

  modport slave (
    input  start, abort, seed, num_cycles, out_flat_i,
    output in_flat_o, vec_valid, busy, done, vec_count, signature
  );
endinterface

// File: rtl/fuzz_stim_sequencer.sv
// LCG-driven stimulus sequencer: fills a vector word by word, applies it atomically and folds
// DUT responses into a 32-bit signature. Define FUZZ_SIG_MISR_EN for a Galois MISR fold.
module fuzz_stim_sequencer #(
  parameter int unsigned IN_W  = 139,
  parameter int unsigned OUT_W = 159,
  parameter logic [31:0] LCG_A = 32'h41C64E6D,
  parameter logic [31:0] LCG_C = 32'h3039
) (
  input  logic                        clk,
  input  logic                        rst_n,
  fuzz_stim_sequencer_if.slave        bus
);

  localparam int unsigned NW = (IN_W + 31) / 32;
  localparam int unsigned KW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [2:0] {StIdle, StFill, StApply, StDrain, StDone} state_e;

  state_e            r_state, w_state_nxt;
  logic [31:0]       r_rng, w_rng_nxt;
  logic [KW-1:0]     r_k, w_k_nxt;
  logic [IN_W-1:0]   r_shadow, w_shadow_nxt;
  logic [IN_W-1:0]   r_in_flat, w_in_flat_nxt;
  logic              r_vec_valid, w_vec_valid_nxt;
  logic [31:0]       r_vec_count, w_vec_count_nxt;
  logic [31:0]       r_num_cycles, w_num_cycles_nxt;
  logic [31:0]       r_signature, w_signature_nxt;

  logic [31:0]       w_rng_step;
  logic [31:0]       w_fold;
  logic [31:0]       w_sig_folded;
  logic [31:0]       w_cnt_inc;

  always_comb begin
    w_rng_step = r_rng * LCG_A + LCG_C;
    w_cnt_inc  = r_vec_count + 32'd1;
  end

  // XOR of all 32-bit chunks of the response; the top chunk is implicitly zero-padded.
  always_comb begin
    w_fold = '0;
    for (int i = 0; i < OUT_W; i++) begin
      w_fold[i % 32] = w_fold[i % 32] ^ bus.out_flat_i[i];
    end
  end

`ifdef FUZZ_SIG_MISR_EN
  always_comb begin
    w_sig_folded = ({r_signature[30:0], 1'b0} ^ (r_signature[31] ? 32'h04C11DB7 : 32'h0))
                   ^ w_fold;
  end
`else
  always_comb begin
    w_sig_folded = {r_signature[30:0], r_signature[31]} ^ w_fold;
  end
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_rng_nxt        = r_rng;
    w_k_nxt          = r_k;
    w_shadow_nxt     = r_shadow;
    w_in_flat_nxt    = r_in_flat;
    w_vec_valid_nxt  = 1'b0;
    w_vec_count_nxt  = r_vec_count;
    w_num_cycles_nxt = r_num_cycles;
    w_signature_nxt  = r_signature;

    if (bus.abort) begin
      w_state_nxt = StIdle;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (bus.start) begin
            w_rng_nxt        = bus.seed;
            w_num_cycles_nxt = bus.num_cycles;
            w_vec_count_nxt  = '0;
            w_signature_nxt  = '0;
            w_k_nxt          = '0;
            w_state_nxt      = StFill;
          end
        end
        StFill: begin
          w_rng_nxt = w_rng_step;
          // Word k lands in shadow bits [32k+31:32k]; the last word is truncated to IN_W.
          for (int i = 0; i < IN_W; i++) begin
            if (r_k == KW'(i / 32)) begin
              w_shadow_nxt[i] = w_rng_step[i % 32];
            end
          end
          w_k_nxt = r_k + 1'b1;
          if (r_k == KW'(NW - 1)) begin
            w_state_nxt = StApply;
          end
        end
        StApply: begin
          w_in_flat_nxt   = r_shadow;
          w_vec_valid_nxt = 1'b1;
          w_vec_count_nxt = w_cnt_inc;
          // The response visible now belongs to the previous vector, if there was one.
          if (r_vec_count != 32'd0) begin
            w_signature_nxt = w_sig_folded;
          end
          if (w_cnt_inc == r_num_cycles + 32'd1) begin
            w_state_nxt = StDrain;
          end else begin
            w_k_nxt     = '0;
            w_state_nxt = StFill;
          end
        end
        StDrain: begin
          w_signature_nxt = w_sig_folded;
          w_state_nxt     = StDone;
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_rng        <= '0;
      r_k          <= '0;
      r_shadow     <= '0;
      r_in_flat    <= '0;
      r_vec_valid  <= 1'b0;
      r_vec_count  <= '0;
      r_num_cycles <= '0;
      r_signature  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rng        <= w_rng_nxt;
      r_k          <= w_k_nxt;
      r_shadow     <= w_shadow_nxt;
      r_in_flat    <= w_in_flat_nxt;
      r_vec_valid  <= w_vec_valid_nxt;
      r_vec_count  <= w_vec_count_nxt;
      r_num_cycles <= w_num_cycles_nxt;
      r_signature  <= w_signature_nxt;
    end
  end

  assign bus.in_flat_o = r_in_flat;
  assign bus.vec_valid = r_vec_valid;
  assign bus.busy      = (r_state == StFill) || (r_state == StApply) || (r_state == StDrain);
  assign bus.done      = (r_state == StDone);
  assign bus.vec_count = r_vec_count;
  assign bus.signature = r_signature;

endmodule

// File: tb/tb_fuzz_stim_sequencer.sv
// Directed bench for fuzz_stim_sequencer: expected vectors are queued at launch and popped
// on each vec_valid pulse; signatures come from a software fold model.
module tb_fuzz_stim_sequencer;
  localparam int unsigned IN_W  = 139;
  localparam int unsigned OUT_W = 159;
  localparam int unsigned NW    = 5;
  localparam logic [31:0] A     = 32'h41C64E6D;
  localparam logic [31:0] C     = 32'h3039;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  fuzz_stim_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) ifc ();

  fuzz_stim_sequencer #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .LCG_A(A),
    .LCG_C(C)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int n_pulses = 0;
  logic [IN_W-1:0] exp_q[$];
  logic [IN_W-1:0] last_vec = '0;
  logic [31:0]     m_rng;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lcg(input logic [31:0] x);
    return x * A + C;
  endfunction

  task automatic push_vecs(input logic [31:0] s, input int count);
    logic [IN_W-1:0] v;
    m_rng = s;
    for (int n = 0; n < count; n++) begin
      v = '0;
      for (int w = 0; w < NW; w++) begin
        m_rng = lcg(m_rng);
        for (int b = 0; b < 32; b++) begin
          if (w * 32 + b < IN_W) v[w*32+b] = m_rng[b];
        end
      end
      exp_q.push_back(v);
    end
  endtask

  function automatic logic [31:0] fold_f(input logic [OUT_W-1:0] o);
    logic [191:0] p;
    logic [31:0]  f;
    p = 192'(o);
    f = '0;
    for (int c = 0; c < 6; c++) f = f ^ p[c*32 +: 32];
    return f;
  endfunction

  function automatic logic [31:0] exp_sig(input logic [OUT_W-1:0] o, input int nfolds);
    logic [31:0] s;
    logic [31:0] f;
    s = '0;
    f = fold_f(o);
    for (int i = 0; i < nfolds; i++) begin
`ifdef FUZZ_SIG_MISR_EN
      s = (s[31] ? ((s << 1) ^ 32'h04C11DB7) : (s << 1)) ^ f;
`else
      s = ((s << 1) | {31'b0, s[31]}) ^ f;
`endif
    end
    return s;
  endfunction

  // One clock step; sampled at the falling edge, consuming a queued vector on each pulse.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (ifc.vec_valid) begin
      n_pulses++;
      chk("vv_spacing", cyc, 6 * n_pulses);
      chk("q_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        last_vec = exp_q.pop_front();
        chk("in_flat", ifc.in_flat_o, last_vec);
      end
    end
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] n, input int npush);
    ifc.seed       = s;
    ifc.num_cycles = n;
    push_vecs(s, npush);
    n_pulses  = 0;
    cyc       = -1;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
  endtask

  task automatic full_run(input logic [31:0] s, input int n, input logic [OUT_W-1:0] outv);
    int dc;
    ifc.out_flat_i = outv;
    launch(s, n, n + 1);
    dc = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ifc.done) begin
        dc = cyc;
        break;
      end
    end
    chk("done_cyc", dc, 6 * (n + 1) + 1);
    chk("pulses", n_pulses, n + 1);
    chk("vec_count", ifc.vec_count, n + 1);
    chk("signature", ifc.signature, exp_sig(outv, n + 1));
    chk("q_drained", exp_q.size(), 0);
    chk("busy_in_done", ifc.busy, 0);
  endtask

  initial begin
    logic [159:0]     rv_wide;
    logic [OUT_W-1:0] rv;

    ifc.start      = 1'b0;
    ifc.abort      = 1'b0;
    ifc.seed       = '0;
    ifc.num_cycles = '0;
    ifc.out_flat_i = '0;

    // Reset held with start asserted.
    #1 rst_n = 1'b0;
    ifc.start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_flat", ifc.in_flat_o, 0);
    chk("rst_vv", ifc.vec_valid, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_count", ifc.vec_count, 0);
    chk("rst_sig", ifc.signature, 0);
    ifc.start = 1'b0;
    rst_n     = 1'b1;
    repeat (4) tick();
    chk("idle_busy", ifc.busy, 0);
    chk("idle_count", ifc.vec_count, 0);

    // Single vector from seed 0.
    full_run(32'h0, 0, '0);
    chk("seed0_w0", ifc.in_flat_o[31:0], 32'h00003039);
    chk("seed0_w1", ifc.in_flat_o[63:32], 32'hD3DC167E);

    // Four vectors, zero response, then constant response of 1.
    full_run(32'hA1500B07, 3, '0);
    chk("sig_zero", ifc.signature, 0);
    full_run(32'hA1500B07, 3, 159'h1);
`ifndef FUZZ_SIG_MISR_EN
    chk("sig_rotxor", ifc.signature, 32'h0000000F);
`endif

    // Wide random response exercises every chunk of the fold.
    rv_wide = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    rv      = rv_wide[OUT_W-1:0];
    full_run(32'h13579BDF, 2, rv);

    // Abort in the third FILL cycle of vector 2.
    ifc.out_flat_i = '0;
    launch(32'h12345678, 3, 1);
    repeat (8) tick();
    ifc.abort = 1'b1;
    tick();
    ifc.abort = 1'b0;
    chk("abort_busy", ifc.busy, 0);
    chk("abort_done", ifc.done, 0);
    chk("abort_count", ifc.vec_count, 1);
    chk("abort_in_flat", ifc.in_flat_o, last_vec);
    ifc.start = 1'b1;
    ifc.abort = 1'b1;
    tick();
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    repeat (2) tick();
    chk("start_abort_busy", ifc.busy, 0);
    full_run(32'h0F0F1234, 1, 159'h5A5A);

    // Start during busy is ignored; async reset mid-run clears outputs before the next edge.
    launch(32'hCAFEF00D, 3, 1);
    repeat (2) tick();
    ifc.start = 1'b1;
    ifc.seed  = 32'h0;
    tick();
    ifc.start = 1'b0;
    repeat (7) tick();
    chk("mid_count", ifc.vec_count, 1);
    chk("mid_busy", ifc.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_flat", ifc.in_flat_o, 0);
    chk("arst_vv", ifc.vec_valid, 0);
    chk("arst_busy", ifc.busy, 0);
    chk("arst_done", ifc.done, 0);
    chk("arst_count", ifc.vec_count, 0);
    chk("arst_sig", ifc.signature, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    full_run(32'h0BAD5EED, 2, rv);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/fuzz_stim_sequencer.md
Name: fuzz_stim_sequencer

Overview:
- Hardware stimulus controller for a flat-port fuzz DUT (`in_flat` / `out_flat`).
- Generates pseudo-random input vectors from a 32-bit LCG, one 32-bit word per cycle, and applies each completed vector atomically.
- Counts applied vectors and folds the DUT's `out_flat` responses into a 32-bit signature, so a run is checked by one compare instead of a full cycle log.

Parameters:
- IN_W, 139, DUT input width; NW = ceil(IN_W/32) words per vector (5 at default).
- OUT_W, 159, DUT output width.
- LCG_A, 32'h41C64E6D, LCG multiplier.
- LCG_C, 32'h3039, LCG increment.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- abort  in  1  terminate the run; return to IDLE.
- seed  in  32  LCG seed, captured on accepted start.
- num_cycles  in  32  vector count after the initial vector; captured on accepted start.
- out_flat_i  in  OUT_W  DUT response.
- in_flat_o  out  IN_W  vector driven to the DUT.
- vec_valid  out  1  one-cycle pulse the cycle a new in_flat_o is visible.
- busy  out  1  high in FILL, APPLY, DRAIN.
- done  out  1  high in DONE.
- vec_count  out  32  vectors applied this run.
- signature  out  32  response signature.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_flat_o=0, vec_valid=0, busy=0, done=0, vec_count=0, signature=0, rng=0, word index k=0.
- LCG step: rng_next = (rng*LCG_A + LCG_C) mod 2^32, full 32-bit product truncation. The first word of a run is step(seed), not seed.
- IDLE/DONE, on start=1:
  - rng<=seed, latch num_cycles, vec_count<=0, signature<=0, k<=0, done<=0.
  - Go to FILL.
- FILL, one cycle per word:
  - rng<=rng_next.
  - Shadow bits [32k+31:32k] <= rng_next; last word is truncated to the low IN_W-32*(NW-1) bits.
  - k++; after word NW-1 go to APPLY. in_flat_o is unchanged during FILL.
- APPLY, one cycle:
  - in_flat_o<=shadow, vec_valid=1 next cycle, vec_count++.
  - If this is not the first vector of the run, fold out_flat_i into signature before the new vector lands.
  - If vec_count (post-increment) == latched num_cycles+1, go to DRAIN; else k<=0, go to FILL.
- Vector period is NW+1 cycles (6 at default); in_flat_o is stable for the whole period.
- DRAIN, one cycle: fold out_flat_i (response to the last vector), then go to DONE.
- DONE: done=1, outputs held; start launches a new run.
- Fold: f = XOR of the 32-bit chunks of out_flat_i, top chunk zero-padded; signature <= {signature[30:0],signature[31]} ^ f.
- Total folds per run = num_cycles+1.
- num_cycles=0: exactly one vector, then DRAIN.
- vec_count is 32-bit. num_cycles=32'hFFFFFFFF makes the terminal count wrap to 0, giving 2^32 vectors; this is accepted, not clamped.
- Simultaneous start and abort: abort wins.
- abort in any state: go to IDLE next edge; in_flat_o, vec_count and signature hold; done=0.
- start while busy: ignored.
- Async reset mid-run: immediate return to reset values; no partial vector is applied.

Optional Feature:
- Macro: FUZZ_SIG_MISR_EN.
- Defined: the fold uses a Galois MISR with polynomial 32'h04C11DB7: sig <= ({sig[30:0],1'b0} ^ (sig[31] ? 32'h04C11DB7 : 0)) ^ f.
- Undefined: rotate-XOR fold as above. Ports, timing and fold count are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with start=1 → all outputs 0, state IDLE; release → nothing happens until start is seen in IDLE.
- seed=0, num_cycles=0, start pulse:
  - in_flat_o[31:0]=32'h00003039 and [63:32]=32'hD3DC167E, appearing 6 cycles after the start edge.
  - vec_valid pulses once, vec_count=1, done rises 1 cycle later.
- seed=32'hA1500B07, num_cycles=3, out_flat_i tied to 0:
  - 4 vec_valid pulses, 6 cycles apart; vec_count=4; signature=0; done 25 cycles after start.
  - in_flat_o words match a software LCG model.
- Same run with out_flat_i=159'h1 constant:
  - signature=32'h0000000F (4 rotate-XOR folds).
  - With FUZZ_SIG_MISR_EN, compare against the reference MISR model.
- abort asserted in the 3rd FILL cycle of vector 2 → IDLE next edge; vec_count=1, in_flat_o unchanged, done=0; a subsequent start restarts cleanly.
- Reset mid-run at cycle 10 → outputs 0 asynchronously, before the next clock edge; start issued during busy is ignored (vec_count is unaffected).
